// File: rtl/padbid_bus_if.sv
// Bundle of the requester handshake and pad-ring signals around the PADBID
// bus arbiter.
//   master : requester / pad-ring side (drives requests and pad_c)
//   slave  : arbiter side (drives grants, pad I/OEN and read results)
// Signals:
//   req_valid/req_wr/req_data : per-channel request, direction and write data
//   req_ready                 : one-hot grant
//   pad_i/pad_oen/pad_c       : PADBID I, OEN (active low) and C pins
//   rd_data/rd_valid/rd_id    : read sample, one-cycle strobe, issuing channel
//   busy                      : arbiter is not idle
interface padbid_bus_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 5
);
  localparam int CHW = $clog2(N_CH);

  logic [N_CH-1:0]       req_valid;
  logic [N_CH-1:0]       req_wr;
  logic [N_CH*WIDTH-1:0] req_data;
  logic [N_CH-1:0]       req_ready;
  logic [WIDTH-1:0]      pad_i;
  logic [WIDTH-1:0]      pad_oen;
  logic [WIDTH-1:0]      pad_c;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic [CHW-1:0]        rd_id;
  logic                  busy;

  modport master (
    output req_valid, req_wr, req_data, pad_c,
    input  req_ready, pad_i, pad_oen, rd_data, rd_valid, rd_id, busy
  );

  modport slave (
    input  req_valid, req_wr, req_data, pad_c,
    output req_ready, pad_i, pad_oen, rd_data, rd_valid, rd_id, busy
  );
endinterface

// File: rtl/padbid_bus_arbiter.sv
// Round-robin arbiter and sequencer for a shared bidirectional PADBID bus.
// N_CH requesters take turns on the bus. A write drives the pads for one cycle
// and is followed by TURN_CYC released cycles. A read releases the pads for one
// cycle and captures pad_c at the end of that cycle.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : padbid_bus_if slave modport (requests, grants, pad pins, read result)
module padbid_bus_arbiter #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 5,
  parameter int TURN_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  padbid_bus_if.slave   bus
);
  localparam int CHW = $clog2(N_CH);
  localparam logic [3:0] TURN_LOAD = 4'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);
  localparam logic [CHW-1:0] PTR_RST = CHW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [3:0]       turn_cnt;
  logic [CHW-1:0]   rd_ch;
  logic [WIDTH-1:0] pad_i_r;
  logic [WIDTH-1:0] pad_oen_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic [CHW-1:0]   rd_id_r;
  logic             busy_r;

  logic [N_CH-1:0]  grant;
  logic [CHW-1:0]   grant_idx;
  logic             grant_any;
  logic [CHW-1:0]   scan_idx;

  // Grant search starts one past the last winner so every channel is served
  // within N_CH accepts. Grants are only offered in IDLE and never during rst.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (state == IDLE && !rst) begin
      for (int k = 1; k <= N_CH; k++) begin
        scan_idx = CHW'((int'(ptr) + k) % N_CH);
        if (!grant_any && bus.req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= PTR_RST;
      turn_cnt   <= '0;
      pad_oen_r  <= '1;
      pad_i_r    <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_id_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr    <= grant_idx;
            busy_r <= 1'b1;
            if (bus.req_wr[grant_idx]) begin
              // pad_i_r doubles as the write-data latch
              pad_i_r   <= bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
              pad_oen_r <= '0;
              state     <= DRIVE;
            end else begin
              rd_ch <= grant_idx;
              state <= SAMPLE;
            end
          end
        end
        DRIVE: begin
          pad_oen_r <= '1;
          pad_i_r   <= '0;
          if (TURN_CYC == 0) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            turn_cnt <= TURN_LOAD;
            state    <= TURN;
          end
        end
        TURN: begin
          if (turn_cnt == 4'd0) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          rd_data_r  <= bus.pad_c;
          rd_id_r    <= rd_ch;
          rd_valid_r <= 1'b1;
          state      <= IDLE;
          busy_r     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.pad_i     = pad_i_r;
  assign bus.pad_oen   = pad_oen_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_id     = rd_id_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_padbid_bus_arbiter.sv
// Directed testbench for padbid_bus_arbiter. Two instances share clk/rst:
// u_dut with TURN_CYC=1 and u_dut3 with TURN_CYC=3, both N_CH=4, WIDTH=5.
module tb_padbid_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  padbid_bus_if #(.N_CH(4), .WIDTH(5)) bus ();
  padbid_bus_if #(.N_CH(4), .WIDTH(5)) bus3 ();

  padbid_bus_arbiter #(.N_CH(4), .WIDTH(5), .TURN_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  padbid_bus_arbiter #(.N_CH(4), .WIDTH(5), .TURN_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;  bus.req_wr = '0;  bus.req_data = '0;  bus.pad_c = '0;
    bus3.req_valid = '0; bus3.req_wr = '0; bus3.req_data = '0; bus3.pad_c = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    bus.req_valid = 4'hF;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.pad_oen !== 5'h1F) begin errors++; $display("FAIL rst_oen: got %h want 1f", bus.pad_oen); end
    checks++; if (bus.pad_i !== 5'h00) begin errors++; $display("FAIL rst_pad_i: got %h want 00", bus.pad_i); end
    checks++; if ({bus.rd_valid, bus.rd_data, bus.rd_id, bus.busy} !== 9'd0) begin errors++; $display("FAIL rst_rd_busy: got rv=%b rd=%h id=%0d busy=%b want all 0", bus.rd_valid, bus.rd_data, bus.rd_id, bus.busy); end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    bus.req_valid = 4'b0001; bus.req_wr = 4'b0001; bus.req_data = {15'd0, 5'h15};
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wr_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.pad_oen !== 5'h00 || bus.pad_i !== 5'h15) begin errors++; $display("FAIL wr_drive: got oen=%h i=%h want 00/15", bus.pad_oen, bus.pad_i); end
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wr_drive_busy: got busy=%b ready=%b want 1/0000", bus.busy, bus.req_ready); end
    tick();
    checks++; if (bus.pad_oen !== 5'h1F || bus.pad_i !== 5'h00 || bus.busy !== 1'b1) begin errors++; $display("FAIL wr_turn: got oen=%h i=%h busy=%b want 1f/00/1", bus.pad_oen, bus.pad_i, bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [4:0] d;
    do_reset();
    bus.req_valid = 4'hF; bus.req_wr = 4'hF;
    bus.req_data = {5'h04, 5'h03, 5'h02, 5'h11};
    for (int n = 0; n < 5; n++) begin
      #1;
      d = 5'(bus.req_data >> (order[n] * 5));
      checks++; if (bus.req_ready !== 4'(1 << order[n]) || bus.pad_oen !== 5'h1F) begin errors++; $display("FAIL rr_grant%0d: got ready=%b oen=%h want ch%0d oen=1f", n, bus.req_ready, bus.pad_oen, order[n]); end
      tick();
      checks++; if (bus.pad_oen !== 5'h00 || bus.pad_i !== d) begin errors++; $display("FAIL rr_drive%0d: got oen=%h i=%h want 00/%h", n, bus.pad_oen, bus.pad_i, d); end
      tick();
      checks++; if (bus.pad_oen !== 5'h1F) begin errors++; $display("FAIL rr_turn%0d: got oen=%h want 1f", n, bus.pad_oen); end
      if (n == 4) bus.req_valid = '0;
      tick();
    end
  endtask

  task automatic test_read();
    do_reset();
    bus.pad_c = 5'h0A;
    bus.req_valid = 4'b0100; bus.req_wr = 4'b0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rd_grant: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.busy !== 1'b1 || bus.pad_oen !== 5'h1F || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_sample: got busy=%b oen=%h rv=%b want 1/1f/0", bus.busy, bus.pad_oen, bus.rd_valid); end
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 5'h0A || bus.rd_id !== 2'd2) begin errors++; $display("FAIL rd_result: got rv=%b rd=%h id=%0d want 1/0a/2", bus.rd_valid, bus.rd_data, bus.rd_id); end
    bus.pad_c = 5'h11;
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 5'h0A || bus.rd_id !== 2'd2) begin errors++; $display("FAIL rd_hold: got rv=%b rd=%h id=%0d want 0/0a/2", bus.rd_valid, bus.rd_data, bus.rd_id); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req_valid = 4'b0100; bus.req_wr = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 5'(r + 4)) begin errors++; $display("FAIL b2b_rd%0d: got rv=%b rd=%h want 1/%h", r, bus.rd_valid, bus.rd_data, 5'(r + 4)); end
      end
      if (r < 3) begin
        bus.pad_c = 5'(r + 5);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_grant%0d: got %b want 0100", r, bus.req_ready); end
        tick();
        tick();
      end else begin
        bus.req_valid = '0;
      end
    end
  endtask

  task automatic test_turn3();
    do_reset();
    bus3.pad_c = 5'h07;
    bus3.req_valid = 4'b0010; bus3.req_wr = 4'b0010; bus3.req_data = {5'h00, 5'h00, 5'h1B, 5'h00};
    #1;
    checks++; if (bus3.req_ready !== 4'b0010) begin errors++; $display("FAIL t3_wgrant: got %b want 0010", bus3.req_ready); end
    tick();
    bus3.req_valid = 4'b1000; bus3.req_wr = 4'b0000;
    #1;
    checks++; if (bus3.req_ready !== 4'b0000 || bus3.pad_oen !== 5'h00 || bus3.pad_i !== 5'h1B) begin errors++; $display("FAIL t3_drive: got ready=%b oen=%h i=%h want 0000/00/1b", bus3.req_ready, bus3.pad_oen, bus3.pad_i); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++; if (bus3.req_ready !== 4'b0000 || bus3.pad_oen !== 5'h1F || bus3.busy !== 1'b1) begin errors++; $display("FAIL t3_turn%0d: got ready=%b oen=%h busy=%b want 0000/1f/1", c, bus3.req_ready, bus3.pad_oen, bus3.busy); end
    end
    tick();
    checks++; if (bus3.req_ready !== 4'b1000) begin errors++; $display("FAIL t3_rgrant: got %b want 1000", bus3.req_ready); end
    tick();
    bus3.req_valid = '0;
    tick();
    checks++; if (bus3.rd_valid !== 1'b1 || bus3.rd_id !== 2'd3 || bus3.rd_data !== 5'h07) begin errors++; $display("FAIL t3_rd: got rv=%b id=%0d rd=%h want 1/3/07", bus3.rd_valid, bus3.rd_id, bus3.rd_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b0010; bus.req_wr = 4'b0010; bus.req_data = {5'h00, 5'h00, 5'h1E, 5'h00};
    tick();
    bus.req_valid = '0;
    checks++; if (bus.pad_oen !== 5'h00) begin errors++; $display("FAIL mid_drive: got oen=%h want 00", bus.pad_oen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.pad_oen !== 5'h1F || bus.busy !== 1'b0 || bus.pad_i !== 5'h00) begin errors++; $display("FAIL mid_release: got oen=%h busy=%b i=%h want 1f/0/00", bus.pad_oen, bus.busy, bus.pad_i); end
    bus.req_valid = 4'b0111; bus.req_wr = 4'b0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 5'h00) begin errors++; $display("FAIL mid_rd_suppress: got rv=%b rd=%h want 0/00", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_rd_wr_mix();
    do_reset();
    bus.pad_c = 5'h13;
    bus.req_valid = 4'b0001; bus.req_wr = 4'b0001; bus.req_data = {5'h00, 5'h00, 5'h0C, 5'h01};
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.req_valid = 4'b0011; bus.req_wr = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mix_first: got %b want 0010", bus.req_ready); end
    tick();
    checks++; if (bus.pad_oen !== 5'h00 || bus.pad_i !== 5'h0C) begin errors++; $display("FAIL mix_drive: got oen=%h i=%h want 00/0c", bus.pad_oen, bus.pad_i); end
    tick();
    tick();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mix_second: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0010;
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_id !== 2'd0 || bus.rd_data !== 5'h13 || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mix_rd_idle: got rv=%b id=%0d rd=%h ready=%b want 1/0/13/0010", bus.rd_valid, bus.rd_id, bus.rd_data, bus.req_ready); end
    bus.req_valid = '0;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_back_to_back();
    test_turn3();
    test_reset_mid();
    test_rd_wr_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/padbid_bus_arbiter.md
# padbid_bus_arbiter

Parametrised arbiter and sequencer for a shared WIDTH-bit bidirectional PADBID pad bus. It succeeds the hand-wired scheme of TBUF/INV enables on a common net with a clocked controller. N_CH requesters share the bus under round-robin arbitration. The block drives the pad I/OEN pins for writes, samples pad C for reads, and enforces a programmable turnaround so that two drivers never overlap. It sits between core-side requesters and the pad ring.

## Interface
- N_CH, 4, number of requesting channels (2..16)
- WIDTH, 5, pad bus width in bits (1..32)
- TURN_CYC, 1, idle cycles with OEN released after every write (0..15)
- CHW, $clog2(N_CH), derived local, channel index width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_CH  per-channel transaction request
- req_wr  in  N_CH  1 = write (drive pads), 0 = read (sample pads)
- req_data  in  N_CH*WIDTH  write data, channel i at [i*WIDTH +: WIDTH]
- req_ready  out  N_CH  one-hot grant; transfer when req_valid[i] & req_ready[i]
- pad_i  out  WIDTH  to PADBID I
- pad_oen  out  WIDTH  to PADBID OEN, active low, all bits equal
- pad_c  in  WIDTH  from PADBID C
- rd_data  out  WIDTH  registered read sample
- rd_valid  out  1  one-cycle pulse, rd_data/rd_id valid
- rd_id  out  CHW  channel that issued the read
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DRIVE, TURN, SAMPLE.
- IDLE:
  - req_ready is combinational from req_valid and the round-robin pointer.
  - Exactly one bit is set if any req_valid is high; otherwise all are 0.
  - req_ready is 0 in every state other than IDLE, and 0 while rst is high.
- Arbitration:
  - Search starts at pointer+1 modulo N_CH.
  - On acceptance the pointer becomes the granted index.
  - Reset value of the pointer is N_CH-1, so channel 0 wins first.
- Accepted write: latch data; IDLE -> DRIVE.
  - DRIVE: pad_oen = all 0, pad_i = latched data, exactly 1 cycle.
  - Then TURN for TURN_CYC cycles, or straight to IDLE if TURN_CYC = 0.
  - TURN uses a 4-bit down-counter loaded with TURN_CYC-1; exit to IDLE when the count reaches 0.
- Accepted read: latch channel index; IDLE -> SAMPLE.
  - SAMPLE: pad_oen = all 1, exactly 1 cycle.
  - At the end of SAMPLE, capture pad_c into rd_data and the index into rd_id.
  - SAMPLE -> IDLE.
- pad_oen = all 1 and pad_i = 0 in every state except DRIVE.
  - The bus is therefore released for at least one cycle (the IDLE accept cycle) between any two writes.
- rd_data and rd_id hold their values until the next read capture.
- req_wr and req_data are sampled only in the accept cycle; later changes are ignored.

## Timing
- Reset values (first cycle after a rst edge):
  - state IDLE, pointer N_CH-1, turn counter 0
  - pad_oen all 1, pad_i 0
  - rd_data 0, rd_valid 0, rd_id 0, busy 0
- Write occupancy: 2 + TURN_CYC cycles (accept, DRIVE, TURN).
  - Pads are driven in the cycle after accept.
- Read occupancy: 2 cycles (accept, SAMPLE).
  - rd_valid pulses in the cycle after SAMPLE, which is also an IDLE accept cycle.
  - Read-to-anything needs no turnaround.
- Back-to-back reads from one channel: one read every 2 cycles.
- Back-to-back writes with TURN_CYC = 0: pad_oen pattern 0,1,0,1.
- rst high mid-transaction: next edge enters IDLE with all reset values.
  - Any pending rd_valid is suppressed.
  - An in-flight write is abandoned and pad_oen is released immediately.
- rst has priority over every other event.
- A request arriving in the same cycle as a read completion is granted in that IDLE cycle.

## Test plan
- Reset, then ch0 write 5'h15 (TURN_CYC=1) -> req_ready=4'b0001 in the same cycle; next cycle pad_oen=5'h00 and pad_i=5'h15; one TURN cycle with pad_oen=5'h1F; busy low on the 4th cycle.
- All four channels hold req_valid with writes -> grants in order 0,1,2,3,0; pad_oen never low in two consecutive cycles.
- ch2 read with pad_c=5'h0A -> rd_valid pulses 2 cycles after the accept with rd_data=5'h0A and rd_id=2; rd_data stays 5'h0A after pad_c changes.
- TURN_CYC=3, ch1 write then ch3 read requested immediately -> read accepted exactly 5 cycles after the write accept; pad_oen=5'h1F throughout the TURN cycles.
- rst asserted during DRIVE -> next cycle pad_oen=5'h1F, busy=0, and channel 0 is granted first on the next request.
- ch0 read and ch1 write pending, pointer=0 -> ch1 granted first, then ch0; rd_valid for ch0 coincides with the next IDLE.
